// File: rtl/mpf_rd_port_mux.sv
// mpf_rd_port_mux
//   Multiplexes N engine read-request ports onto the single MPF c0 read channel.
//   A round-robin arbiter picks at most one eligible port per cycle, the winning
//   request is registered onto c0tx with the port id in the top mdata bits, and
//   c0rx responses are steered back to the owning port using that tag. Each port
//   keeps an in-flight counter that both limits its outstanding reads and drives
//   its not-empty indication.
module mpf_rd_port_mux #(
   parameter int N_PORTS     = 4,
   parameter int ADDR_W      = 42,
   parameter int MDATA_W     = 16,
   parameter int MAX_OUTST   = 64,
   parameter int VIRT_ADDR   = 1,
   parameter int MAP_VC      = 1,
   parameter int CHECK_ORDER = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,

   input  logic [N_PORTS-1:0]         req_valid,
   input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
   input  logic [N_PORTS*MDATA_W-1:0] req_mdata,
   output logic [N_PORTS-1:0]         req_ready,

   output logic                       c0tx_valid,
   output logic [ADDR_W-1:0]          c0tx_addr,
   output logic [MDATA_W-1:0]         c0tx_mdata,
   output logic [2:0]                 c0tx_ext,
   input  logic                       c0tx_alm_full,

   input  logic                       c0rx_valid,
   input  logic [MDATA_W-1:0]         c0rx_mdata,
   input  logic [511:0]               c0rx_data,

   output logic [N_PORTS-1:0]         rsp_valid,
   output logic [MDATA_W-1:0]         rsp_mdata,
   output logic [511:0]               rsp_data,

   output logic [N_PORTS-1:0]         port_not_empty,
   output logic                       not_empty,
   output logic                       err_unexp_rsp
);

   // Tag field width; a single port needs no tag at all. TAG_W is the storage
   // width used for port indices so that the N_PORTS=1 case never needs a
   // zero-width vector.
   localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 0;
   localparam int TAG_W  = (PORT_W > 0) ? PORT_W : 1;
   localparam int USER_W = MDATA_W - PORT_W;
   localparam int CNT_W  = $clog2(MAX_OUTST + 1);

   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [MDATA_W-1:0] USER_MASK = {MDATA_W{1'b1}} >> PORT_W;
   localparam logic [TAG_W-1:0]   LAST_PORT = TAG_W'(N_PORTS - 1);
   localparam logic [2:0]         EXT_FLAGS = {(CHECK_ORDER != 0), (MAP_VC != 0), (VIRT_ADDR != 0)};

   // Control state
   logic [TAG_W-1:0] rr_start;              // first port the arbiter considers
   logic [CNT_W-1:0] cnt     [N_PORTS];     // reads in flight per port
   logic [CNT_W-1:0] cnt_nxt [N_PORTS];

   // Stage p0: arbitration and response decode (combinational)
   logic [N_PORTS-1:0] elig_p0;
   logic [N_PORTS-1:0] grant_p0;
   logic [TAG_W-1:0]   grant_id_p0;
   logic               grant_any_p0;
   logic [ADDR_W-1:0]  sel_addr_p0;
   logic [MDATA_W-1:0] sel_mdata_p0;
   logic [MDATA_W-1:0] iss_mdata_p0;
   logic [TAG_W-1:0]   rx_tag_p0;
   logic               rx_tag_ok_p0;
   logic [N_PORTS-1:0] rx_hit_p0;
   logic [N_PORTS-1:0] unexp_p0;
   logic [N_PORTS-1:0] pne_nxt;
   logic               bad_tag_p0;

   // Extract the response tag; tags that name a non-existent port are rejected.
   if (PORT_W > 0) begin : g_tag
      assign rx_tag_p0    = c0rx_mdata[MDATA_W-1 -: TAG_W];
      assign rx_tag_ok_p0 = (32'(rx_tag_p0) < 32'(N_PORTS));
   end else begin : g_notag
      assign rx_tag_p0    = '0;
      assign rx_tag_ok_p0 = 1'b1;
   end

   assign bad_tag_p0 = c0rx_valid && !rx_tag_ok_p0;

   // Per-port eligibility: pending request, spare credit, MPF not almost full.
   always_comb begin
      elig_p0 = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         elig_p0[i] = reset_n && req_valid[i] && (cnt[i] < CNT_MAX) && !c0tx_alm_full;
      end
   end

   // Round-robin search starting at rr_start; first eligible port wins.
   always_comb begin
      grant_p0     = '0;
      grant_id_p0  = '0;
      grant_any_p0 = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!grant_any_p0 && elig_p0[(int'(rr_start) + k) % N_PORTS]) begin
            grant_p0[(int'(rr_start) + k) % N_PORTS] = 1'b1;
            grant_id_p0  = TAG_W'((int'(rr_start) + k) % N_PORTS);
            grant_any_p0 = 1'b1;
         end
      end
   end

   assign req_ready = grant_p0;

   // Select the winning port's address and mdata (grant is one-hot or zero).
   always_comb begin
      sel_addr_p0  = '0;
      sel_mdata_p0 = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant_p0[i]) begin
            sel_addr_p0  = req_addr[i*ADDR_W +: ADDR_W];
            sel_mdata_p0 = req_mdata[i*MDATA_W +: MDATA_W];
         end
      end
   end

   // Replace the top mdata bits with the port id so the response can find its way back.
   assign iss_mdata_p0 = (MDATA_W'(grant_id_p0) << USER_W) | (sel_mdata_p0 & USER_MASK);

   // Decode which port the incoming response belongs to.
   always_comb begin
      rx_hit_p0 = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         rx_hit_p0[i] = c0rx_valid && rx_tag_ok_p0 && (rx_tag_p0 == TAG_W'(i));
      end
   end

   // Next in-flight count per port; a response against an empty count is flagged
   // and never wraps the counter.
   always_comb begin
      unexp_p0 = '0;
      pne_nxt  = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         cnt_nxt[i] = cnt[i];
         case ({grant_p0[i], rx_hit_p0[i]})
            2'b10: cnt_nxt[i] = cnt[i] + CNT_ONE;
            2'b01: begin
               if (cnt[i] == '0) begin
                  unexp_p0[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = cnt[i] - CNT_ONE;
               end
            end
            2'b11: begin
               // The response cannot belong to the read being granted now, so
               // an empty count still counts as unexpected; the new read is kept.
               if (cnt[i] == '0) begin
                  unexp_p0[i] = 1'b1;
                  cnt_nxt[i]  = CNT_ONE;
               end
            end
            default: cnt_nxt[i] = cnt[i];
         endcase
         pne_nxt[i] = (cnt_nxt[i] != '0) || grant_p0[i];
      end
   end

   // Stage p1: arbitration pointer, credit counters, occupancy and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_start       <= '0;
         port_not_empty <= '0;
         not_empty      <= 1'b0;
         err_unexp_rsp  <= 1'b0;
         for (int i = 0; i < N_PORTS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         if (grant_any_p0) begin
            rr_start <= (grant_id_p0 == LAST_PORT) ? '0 : grant_id_p0 + TAG_W'(1);
         end
         for (int i = 0; i < N_PORTS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         port_not_empty <= pne_nxt;
         not_empty      <= |pne_nxt;
         if (|unexp_p0 || bad_tag_p0) begin
            err_unexp_rsp <= 1'b1;
         end
      end
   end

   // Stage p1: registered issue onto c0tx, flags only present with a valid request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c0tx_valid <= 1'b0;
         c0tx_ext   <= '0;
         c0tx_addr  <= '0;
         c0tx_mdata <= '0;
      end else begin
         c0tx_valid <= grant_any_p0;
         c0tx_ext   <= grant_any_p0 ? EXT_FLAGS : 3'b000;
         if (grant_any_p0) begin
            c0tx_addr  <= sel_addr_p0;
            c0tx_mdata <= iss_mdata_p0;
         end
      end
   end

   // Stage p1: registered response demux; payload holds between responses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= '0;
         rsp_mdata <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rx_hit_p0;
         if (c0rx_valid && rx_tag_ok_p0) begin
            rsp_mdata <= c0rx_mdata & USER_MASK;
            rsp_data  <= c0rx_data;
         end
      end
   end

endmodule

// File: tb/tb_mpf_rd_port_mux.sv
// Bench for mpf_rd_port_mux: table of per-cycle vectors with expected grants,
// issue and response expectations tracked through a scoreboard, plus hand
// sequences for reset, sticky error and out-of-range tags.
module tb_mpf_rd_port_mux;
   localparam int N    = 4;
   localparam int AW   = 42;
   localparam int MW   = 16;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*MW-1:0]   req_mdata;
   logic [N-1:0]      req_ready;
   logic              c0tx_valid;
   logic [AW-1:0]     c0tx_addr;
   logic [MW-1:0]     c0tx_mdata;
   logic [2:0]        c0tx_ext;
   logic              c0tx_alm_full;
   logic              c0rx_valid;
   logic [MW-1:0]     c0rx_mdata;
   logic [511:0]      c0rx_data;
   logic [N-1:0]      rsp_valid;
   logic [MW-1:0]     rsp_mdata;
   logic [511:0]      rsp_data;
   logic [N-1:0]      port_not_empty;
   logic              not_empty;
   logic              err_unexp_rsp;

   // Three-port instance for the out-of-range tag case
   logic [2:0]        req_valid3;
   logic [3*AW-1:0]   req_addr3;
   logic [3*MW-1:0]   req_mdata3;
   logic [2:0]        req_ready3;
   logic              c0tx_valid3;
   logic [AW-1:0]     c0tx_addr3;
   logic [MW-1:0]     c0tx_mdata3;
   logic [2:0]        c0tx_ext3;
   logic              c0rx_valid3;
   logic [MW-1:0]     c0rx_mdata3;
   logic [2:0]        rsp_valid3;
   logic [MW-1:0]     rsp_mdata3;
   logic [511:0]      rsp_data3;
   logic [2:0]        port_not_empty3;
   logic              not_empty3;
   logic              err_unexp_rsp3;

   mpf_rd_port_mux #(.N_PORTS(N), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTST(MAXO),
                     .VIRT_ADDR(1), .MAP_VC(1), .CHECK_ORDER(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_ready(req_ready),
      .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
      .c0tx_ext(c0tx_ext), .c0tx_alm_full(c0tx_alm_full),
      .c0rx_valid(c0rx_valid), .c0rx_mdata(c0rx_mdata), .c0rx_data(c0rx_data),
      .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
      .port_not_empty(port_not_empty), .not_empty(not_empty), .err_unexp_rsp(err_unexp_rsp)
   );

   mpf_rd_port_mux #(.N_PORTS(3), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTST(MAXO),
                     .VIRT_ADDR(1), .MAP_VC(1), .CHECK_ORDER(1)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid3), .req_addr(req_addr3), .req_mdata(req_mdata3), .req_ready(req_ready3),
      .c0tx_valid(c0tx_valid3), .c0tx_addr(c0tx_addr3), .c0tx_mdata(c0tx_mdata3),
      .c0tx_ext(c0tx_ext3), .c0tx_alm_full(1'b0),
      .c0rx_valid(c0rx_valid3), .c0rx_mdata(c0rx_mdata3), .c0rx_data(c0rx_data),
      .rsp_valid(rsp_valid3), .rsp_mdata(rsp_mdata3), .rsp_data(rsp_data3),
      .port_not_empty(port_not_empty3), .not_empty(not_empty3), .err_unexp_rsp(err_unexp_rsp3)
   );

   typedef struct {
      logic [3:0]  v;     // req_valid
      logic        af;    // c0tx_alm_full
      logic        rxv;   // c0rx_valid
      logic [15:0] rxm;   // c0rx_mdata
      logic [3:0]  rdy;   // expected req_ready
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [MW-1:0] m;
   } iss_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   iss_t iss_q[$];

   logic         rsp_pend = 1'b0;
   logic [3:0]   exp_rv;
   logic [MW-1:0] exp_rm;
   logic [511:0] exp_rd;
   logic [MW-1:0] last_rm = '0;
   logic [511:0] last_rd = '0;

   vec_t tbl[25];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic af, input logic rxv,
                               input logic [15:0] rxm, input logic [3:0] rdy);
      vec_t r;
      r.v = v; r.af = af; r.rxv = rxv; r.rxm = rxm; r.rdy = rdy;
      return r;
   endfunction

   function automatic logic [AW-1:0] addr_of(input int c, input int p);
      return AW'(32'h1000 + 32'(c * 16 + p));
   endfunction

   // User mdata deliberately carries 2'b11 in the tag field, which must be overwritten.
   function automatic logic [MW-1:0] mdata_in(input int c, input int p);
      return {2'b11, 14'(c * 8 + p)};
   endfunction

   function automatic logic [511:0] data_of(input int c);
      return {16{32'hA5A5_0000 + 32'(c)}};
   endfunction

   task automatic set_reqs(input int c);
      for (int p = 0; p < N; p++) begin
         req_addr[p*AW +: AW]  = addr_of(c, p);
         req_mdata[p*MW +: MW] = mdata_in(c, p);
      end
   endtask

   // One clock of table-driven stimulus: drive, check at negedge, update scoreboard.
   task automatic run_cycle(input vec_t t);
      iss_t e;
      int   gp;
      req_valid     = t.v;
      c0tx_alm_full = t.af;
      c0rx_valid    = t.rxv;
      c0rx_mdata    = t.rxm;
      c0rx_data     = data_of(cyc);
      set_reqs(cyc);
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(t.rdy));
      if (iss_q.size() > 0) begin
         e = iss_q.pop_front();
         chk("c0tx_valid", 64'(c0tx_valid), 64'd1);
         chk("c0tx_addr", 64'(c0tx_addr), 64'(e.a));
         chk("c0tx_mdata", 64'(c0tx_mdata), 64'(e.m));
         chk("c0tx_ext", 64'(c0tx_ext), 64'h7);
      end else begin
         chk("c0tx_valid idle", 64'(c0tx_valid), 64'd0);
         chk("c0tx_ext idle", 64'(c0tx_ext), 64'd0);
      end
      if (t.rdy != 4'd0) begin
         gp = 0;
         for (int p = 0; p < N; p++) if (t.rdy[p]) gp = p;
         e.a = addr_of(cyc, gp);
         e.m = {2'(gp), 14'(cyc * 8 + gp)};
         iss_q.push_back(e);
      end
      if (rsp_pend) begin
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         chk("rsp_mdata", 64'(rsp_mdata), 64'(exp_rm));
         chk_data("rsp_data", rsp_data, exp_rd);
         last_rm = exp_rm;
         last_rd = exp_rd;
      end else begin
         chk("rsp_valid idle", 64'(rsp_valid), 64'd0);
         chk("rsp_mdata hold", 64'(rsp_mdata), 64'(last_rm));
         chk_data("rsp_data hold", rsp_data, last_rd);
      end
      rsp_pend = t.rxv;
      if (t.rxv) begin
         exp_rv = 4'b0001 << t.rxm[15:14];
         exp_rm = t.rxm & 16'h3FFF;
         exp_rd = data_of(cyc);
      end
      chk("err_unexp_rsp clear", 64'(err_unexp_rsp), 64'd0);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Fairness: all ports requesting, grants rotate 0,1,2,3,...
      for (int i = 0; i < 8; i++) tbl[i] = mk(4'hF, 1'b0, 1'b0, 16'h0, 4'b0001 << (i % 4));
      tbl[8]  = mk(4'h0, 1'b0, 1'b0, 16'h0000, 4'h0);
      // Response routing: tag 3 returns to port 3 with tag bits cleared
      tbl[9]  = mk(4'h0, 1'b0, 1'b1, 16'hC0A5, 4'h0);
      // Same-cycle grant and response on port 3 keeps its count at 1,
      // so exactly three further grants fit before the credit limit
      tbl[10] = mk(4'h8, 1'b0, 1'b1, 16'hC0A6, 4'h8);
      tbl[11] = mk(4'h8, 1'b0, 1'b0, 16'h0000, 4'h8);
      tbl[12] = mk(4'h8, 1'b0, 1'b0, 16'h0000, 4'h8);
      tbl[13] = mk(4'h8, 1'b0, 1'b0, 16'h0000, 4'h8);
      tbl[14] = mk(4'h8, 1'b0, 1'b0, 16'h0000, 4'h0);
      // Credit limit on port 2 (already at 2), released by one response
      tbl[15] = mk(4'h4, 1'b0, 1'b0, 16'h0000, 4'h4);
      tbl[16] = mk(4'h4, 1'b0, 1'b0, 16'h0000, 4'h4);
      tbl[17] = mk(4'h4, 1'b0, 1'b0, 16'h0000, 4'h0);
      tbl[18] = mk(4'h4, 1'b0, 1'b1, 16'h8011, 4'h0);
      tbl[19] = mk(4'h4, 1'b0, 1'b0, 16'h0000, 4'h4);
      // Backpressure: grant issues, then nothing while almost full, then resumes
      tbl[20] = mk(4'h3, 1'b0, 1'b0, 16'h0000, 4'h1);
      tbl[21] = mk(4'h3, 1'b1, 1'b0, 16'h0000, 4'h0);
      tbl[22] = mk(4'h3, 1'b1, 1'b0, 16'h0000, 4'h0);
      tbl[23] = mk(4'h3, 1'b0, 1'b0, 16'h0000, 4'h2);
      tbl[24] = mk(4'h0, 1'b0, 1'b0, 16'h0000, 4'h0);

      reset_n       = 1'b0;
      req_valid     = 4'hF;
      c0tx_alm_full = 1'b0;
      c0rx_valid    = 1'b0;
      c0rx_mdata    = '0;
      c0rx_data     = '0;
      set_reqs(0);
      req_valid3    = '0;
      req_addr3     = '0;
      req_mdata3    = '0;
      c0rx_valid3   = 1'b0;
      c0rx_mdata3   = '0;

      // Reset state with all ports requesting
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 64'(req_ready), 64'd0);
      chk("reset c0tx_valid", 64'(c0tx_valid), 64'd0);
      chk("reset c0tx_ext", 64'(c0tx_ext), 64'd0);
      chk("reset c0tx_addr", 64'(c0tx_addr), 64'd0);
      chk("reset c0tx_mdata", 64'(c0tx_mdata), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset rsp_mdata", 64'(rsp_mdata), 64'd0);
      chk("reset port_not_empty", 64'(port_not_empty), 64'd0);
      chk("reset not_empty", 64'(not_empty), 64'd0);
      chk("reset err", 64'(err_unexp_rsp), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < 25; i++) run_cycle(tbl[i]);

      // Counts now 3,3,4,4: every port reports reads in flight
      @(negedge clk);
      chk("final port_not_empty", 64'(port_not_empty), 64'hF);
      chk("final not_empty", 64'(not_empty), 64'd1);
      chk("final c0tx_valid", 64'(c0tx_valid), 64'd0);
      chk("queue drained", 64'(iss_q.size()), 64'd0);

      // Mid-burst asynchronous reset drops tracking immediately
      @(posedge clk);
      #1;
      reset_n   = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("midreset req_ready", 64'(req_ready), 64'd0);
      chk("midreset port_not_empty", 64'(port_not_empty), 64'd0);
      chk("midreset not_empty", 64'(not_empty), 64'd0);
      chk("midreset err", 64'(err_unexp_rsp), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      req_valid = 4'h0;

      // Response to port 1 with a zero count sets the sticky error
      c0rx_valid = 1'b1;
      c0rx_mdata = 16'h4033;
      @(posedge clk);
      #1;
      c0rx_valid = 1'b0;
      @(negedge clk);
      chk("unexpected rsp err", 64'(err_unexp_rsp), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err sticky", 64'(err_unexp_rsp), 64'd1);

      // Three-port instance: tag 3 does not exist, response dropped and flagged
      chk("dut3 err before", 64'(err_unexp_rsp3), 64'd0);
      @(posedge clk);
      #1;
      c0rx_valid3 = 1'b1;
      c0rx_mdata3 = 16'hC001;
      @(posedge clk);
      #1;
      c0rx_valid3 = 1'b0;
      @(negedge clk);
      chk("dut3 bad tag rsp_valid", 64'(rsp_valid3), 64'd0);
      chk("dut3 bad tag err", 64'(err_unexp_rsp3), 64'd1);
      chk("dut3 bad tag not_empty", 64'(not_empty3), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
